// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM states, ALU opcodes,
// requester indices and a small one-hot helper.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (used by alu_rr_grant).
package alu_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Settle counter is wide enough for ALU_LAT up to 15
   localparam int CNT_W = 4;

   // Opcodes shared with the ALU top
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLT = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;

   // Requester indices: instruction datapath and PC/branch-target unit
   localparam int REQ_DP = 0;
   localparam int REQ_PC = 1;

   // Turns a requester index into its one-hot 2-bit vector
   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Two-way combinational grant for the shared ALU.
// Default build alternates on a tie using last_grant; with
// ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie.
module alu_rr_grant
   import alu_share_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   // Pick exactly one valid requester when the arbiter is able to accept
   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
               grant = req_onehot(1'(REQ_DP));
`else
               grant = req_onehot(~last_grant);
`endif
            end
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares the single multicycle-datapath ALU between the instruction datapath
// (req 0) and the PC/branch-target unit (req 1). Latches the granted request,
// holds it on the ALU for ALU_LAT cycles, then returns a one-cycle response.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority tie-break).
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int OP_W    = 3,
   parameter int ALU_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*OP_W-1:0]  req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [OP_W-1:0]    alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_zero,
   output logic [1:0]         resp_valid,
   output logic [WIDTH-1:0]   resp_data,
   output logic               resp_zero,
   output logic               busy
);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic               last_grant;
   logic [OP_W-1:0]    op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   resp_data_r;
   logic               resp_zero_r;
   logic [1:0]         grant;
   logic               grant_en;
   logic               grant_idx;
   logic               transfer;
   logic               capture;

   assign grant_en  = (state == ST_IDLE) && !rst;
   assign grant_idx = grant[1];

   alu_rr_grant u_grant (
      .valid      (req_valid),
      .last_grant (last_grant),
      .en         (grant_en),
      .grant      (grant)
   );

   // State register; reset drops any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake/response strobes
   always_comb begin
      state_next = state;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      transfer   = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = grant;
            if (|(req_valid & grant)) begin
               transfer   = 1'b1;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt == '0) begin
               capture    = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            resp_valid = req_onehot(last_grant);
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (rst) begin
         req_ready  = 2'b00;
         resp_valid = 2'b00;
      end
   end

   // Operand latch, settle counter, grant history and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         cnt         <= '0;
         last_grant  <= 1'b1;
         resp_data_r <= '0;
         resp_zero_r <= 1'b0;
      end else begin
         if (transfer) begin
            op_r       <= grant_idx ? req_op[OP_W +: OP_W]   : req_op[0 +: OP_W];
            a_r        <= grant_idx ? req_a[WIDTH +: WIDTH]  : req_a[0 +: WIDTH];
            b_r        <= grant_idx ? req_b[WIDTH +: WIDTH]  : req_b[0 +: WIDTH];
            cnt        <= CNT_W'(ALU_LAT - 1);
            last_grant <= grant_idx;
         end
         if ((state == ST_EXEC) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            resp_data_r <= alu_result;
            resp_zero_r <= alu_zero;
         end
      end
   end

   assign alu_op    = rst ? '0   : op_r;
   assign alu_a     = rst ? '0   : a_r;
   assign alu_b     = rst ? '0   : b_r;
   assign resp_data = rst ? '0   : resp_data_r;
   assign resp_zero = rst ? 1'b0 : resp_zero_r;
   assign busy      = (state != ST_IDLE) && !rst;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
// Honours ALU_ARB_FIXED_PRIO_EN when choosing the expected grant order.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [5:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [1:0]  resp_valid;
   logic [31:0] resp_data;
   logic        resp_zero;
   logic        busy;

   int passCount  = 0;
   int failCount  = 0;
   int totalCount = 0;

   logic [1:0]  rrExpValid [4];
   logic [31:0] rrExpData  [4];

   alu_share_arbiter #(.WIDTH(32), .OP_W(3), .ALU_LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_zero  (resp_zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the gate-level ALU
   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_XOR: alu_result = alu_a ^ alu_b;
         ALU_SLT: alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
         ALU_NOR: alu_result = ~(alu_a | alu_b);
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == 32'h0);
   end

   task automatic applyStimulus(input logic [1:0] valid,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
      req_valid = valid;
      req_op    = {op1, op0};
      req_a     = {a1, a0};
      req_b     = {b1, b0};
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      rrExpValid = '{2'b01, 2'b01, 2'b01, 2'b01};
      rrExpData  = '{32'd12, 32'd12, 32'd12, 32'd12};
`else
      rrExpValid = '{2'b01, 2'b10, 2'b01, 2'b10};
      rrExpData  = '{32'd12, 32'd99, 32'd12, 32'd99};
`endif

      // Reset state
      rst = 1'b1;
      applyStimulus(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
      @(negedge clk);
      nextCycle();
      checkOutput("rst_busy",       32'(busy),       0);
      checkOutput("rst_req_ready",  32'(req_ready),  0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 0);
      checkOutput("rst_resp_data",  resp_data,       0);
      checkOutput("rst_alu_a",      alu_a,           0);
      checkOutput("rst_alu_op",     32'(alu_op),     0);

      // Single req 0 XOR, response three cycles after accept
      rst = 1'b0;
      applyStimulus(2'b01, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_ADD, 0, 0);
      #1;
      checkOutput("xor_ready", 32'(req_ready), 32'b01);
      checkOutput("xor_idle_busy", 32'(busy), 0);
      nextCycle();
      applyStimulus(2'b00, ALU_XOR, 32'hDEAD_BEEF, 32'h0, ALU_ADD, 0, 0);
      checkOutput("xor_exec_busy",  32'(busy),      1);
      checkOutput("xor_exec_ready", 32'(req_ready), 0);
      checkOutput("xor_alu_op",     32'(alu_op),    32'(ALU_XOR));
      checkOutput("xor_alu_a",      alu_a,          32'hF0F0_F0F0);
      checkOutput("xor_alu_b",      alu_b,          32'h0FF0_0FF0);
      checkOutput("xor_t1_resp",    32'(resp_valid), 0);
      nextCycle();
      checkOutput("xor_t2_resp",    32'(resp_valid), 0);
      nextCycle();
      checkOutput("xor_t3_resp",    32'(resp_valid), 32'b01);
      checkOutput("xor_t3_data",    resp_data,       32'hFF00_FF00);
      checkOutput("xor_t3_zero",    32'(resp_zero),  0);
      nextCycle();
      checkOutput("xor_t4_resp",    32'(resp_valid), 0);
      checkOutput("xor_t4_busy",    32'(busy),       0);
      checkOutput("xor_hold_alu_a", alu_a,           32'hF0F0_F0F0);

      // Both requesters valid right after reset
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      applyStimulus(2'b11, ALU_ADD, 32'd5, 32'd7, ALU_SUB, 32'd100, 32'd1);
      #1;
      checkOutput("tie_first_ready", 32'(req_ready), 32'b01);
      for (int k = 0; k < 4; k++) begin
         repeat (3) nextCycle();
         checkOutput($sformatf("tie_resp_valid_%0d", k), 32'(resp_valid), 32'(rrExpValid[k]));
         checkOutput($sformatf("tie_resp_data_%0d", k),  resp_data,       rrExpData[k]);
         if (k == 3) applyStimulus(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
         nextCycle();
         if (k < 3) checkOutput($sformatf("tie_ready_%0d", k + 1), 32'(req_ready), 32'(rrExpValid[k + 1]));
         else       checkOutput("tie_end_busy", 32'(busy), 0);
      end

      // Operand change during EXEC is ignored; equal XOR gives zero
      applyStimulus(2'b01, ALU_XOR, 32'h1234_5678, 32'h1234_5678, ALU_ADD, 0, 0);
      nextCycle();
      applyStimulus(2'b00, ALU_XOR, 32'h1234_5678, 32'h0, ALU_ADD, 0, 0);
      checkOutput("hold_alu_b", alu_b, 32'h1234_5678);
      nextCycle();
      nextCycle();
      checkOutput("eq_resp_valid", 32'(resp_valid), 32'b01);
      checkOutput("eq_resp_data",  resp_data,       0);
      checkOutput("eq_resp_zero",  32'(resp_zero),  1);
      nextCycle();

      // Reset pulse mid-EXEC drops the op
      applyStimulus(2'b10, ALU_ADD, 0, 0, ALU_ADD, 32'd1, 32'd2);
      #1;
      checkOutput("mid_ready_req1", 32'(req_ready), 32'b10);
      nextCycle();
      rst = 1'b1;
      applyStimulus(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
      #1;
      checkOutput("mid_rst_busy",  32'(busy),       0);
      checkOutput("mid_rst_alu_a", alu_a,           0);
      checkOutput("mid_rst_alu_b", alu_b,           0);
      checkOutput("mid_rst_resp",  32'(resp_valid), 0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(2'b01, ALU_OR, 32'd3, 32'd12, ALU_ADD, 0, 0);
      #1;
      checkOutput("post_rst_ready", 32'(req_ready), 32'b01);
      for (int i = 1; i <= 3; i++) begin
         nextCycle();
         if (i == 1) applyStimulus(2'b00, ALU_OR, 0, 0, ALU_ADD, 0, 0);
         if (i < 3) begin
            checkOutput($sformatf("post_rst_quiet_%0d", i), 32'(resp_valid), 0);
         end else begin
            checkOutput("post_rst_resp", 32'(resp_valid), 32'b01);
            checkOutput("post_rst_data", resp_data,       32'd15);
         end
      end
      nextCycle();

      // Req 1 pulses valid while busy and is never granted
      applyStimulus(2'b01, ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, ALU_ADD, 0, 0);
      nextCycle();
      applyStimulus(2'b10, ALU_AND, 0, 0, ALU_SLT, 32'd1, 32'd2);
      #1;
      checkOutput("drop_ready_t1", 32'(req_ready), 0);
      nextCycle();
      applyStimulus(2'b00, ALU_AND, 0, 0, ALU_SLT, 0, 0);
      checkOutput("drop_ready_t2", 32'(req_ready), 0);
      nextCycle();
      checkOutput("drop_resp_valid", 32'(resp_valid), 32'b01);
      checkOutput("drop_resp_data",  resp_data,       32'h0F0F_0000);
      checkOutput("drop_ready_t3",   32'(req_ready),  0);
      for (int j = 0; j < 2; j++) begin
         nextCycle();
         checkOutput($sformatf("drop_quiet_resp_%0d", j),  32'(resp_valid), 0);
         checkOutput($sformatf("drop_quiet_busy_%0d", j),  32'(busy),       0);
         checkOutput($sformatf("drop_quiet_ready_%0d", j), 32'(req_ready),  0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
